rr_hold_arbiter: RTL



---
 rtl/rr_hold_arbiter_pkg.sv | 16 +
 rtl/rr_hold_arbiter_if.sv | 9 +
 rtl/rr_hold_arbiter_pick.sv | 25 ++
 rtl/rr_hold_arbiter.sv | 73 +++++++
 4 files changed

// File: rtl/rr_hold_arbiter_pkg.sv
// arb_pkg: shared FSM states, default sizing and one-hot/index helpers for the round-robin hold arbiter.
package arb_pkg;
   typedef enum logic {IDLE, GRANT} state_e;
   localparam int ARB_N = 3;
   localparam int ARB_MAX_HOLD = 4;
   localparam int ARB_IDXW = 2;
   function automatic logic [31:0] idx2oh(input logic [4:0] idx);
      return 32'd1 << idx;
   endfunction
   function automatic logic [4:0] oh2idx(input logic [31:0] oh);
      logic [4:0] r;
      r = '0;
      for (int i = 0; i < 32; i++) r = oh[i] ? (r | 5'(i)) : r;
      return r;
   endfunction
endpackage

// File: rtl/rr_hold_arbiter_if.sv
// rr_hold_arbiter_if: request/grant bundle between the requesting agents (master) and the arbiter (slave).
interface rr_hold_arbiter_if import arb_pkg::*; #(parameter int N = ARB_N, parameter int IDXW = ARB_IDXW);
   logic [N-1:0] req;
   logic [N-1:0] grant;
   logic grant_valid;
   logic [IDXW-1:0] grant_idx;
   modport master(output req, input grant, grant_valid, grant_idx);
   modport slave(input req, output grant, grant_valid, grant_idx);
endinterface

// File: rtl/rr_hold_arbiter_pick.sv
// rr_pick: combinational round-robin picker, first set bit of req_i searching upward from ptr_i with wrap.
module rr_pick import arb_pkg::*; #(
   parameter int N = ARB_N,
   parameter int IDXW = ARB_IDXW
) (
   input  logic [N-1:0]    req_i,
   input  logic [IDXW-1:0] ptr_i,
   output logic            found_o,
   output logic [N-1:0]    onehot_o,
   output logic [IDXW-1:0] idx_o
);
   localparam logic [IDXW:0] NW = (IDXW+1)'(N);
   logic [N-1:0] rot;
   logic [IDXW-1:0] pos;
   logic [IDXW:0] sum;
   always_comb begin
      rot = N'({req_i, req_i} >> ptr_i);
      pos = '0;
      for (int k = N - 1; k >= 0; k--) pos = rot[k] ? IDXW'(k) : pos;
      sum = {1'b0, ptr_i} + {1'b0, pos};
      found_o = |req_i;
      idx_o = IDXW'(sum >= NW ? sum - NW : sum);
      onehot_o = found_o ? N'(idx2oh(5'(idx_o))) : '0;
   end
endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: registered one-hot round-robin arbiter; the owner keeps the grant
// while requesting, but yields after MAX_HOLD cycles when someone else is waiting.
module rr_hold_arbiter import arb_pkg::*; #(
   parameter int N = ARB_N,
   parameter int MAX_HOLD = ARB_MAX_HOLD,
   parameter int IDXW = ARB_IDXW
) (
   input logic clk,
   input logic res,
   rr_hold_arbiter_if.slave bus
);
   localparam int HW = MAX_HOLD > 1 ? $clog2(MAX_HOLD) : 1;
   localparam logic [HW-1:0] HMAX = HW'(MAX_HOLD - 1);
   state_e state_q, state_d;
   logic [N-1:0] grant_q, grant_d;
   logic [IDXW-1:0] ptr_q, ptr_d, idx_q, idx_d;
   logic [HW-1:0] hold_q, hold_d;
   logic own;
   logic raw_found, oth_found;
   logic [N-1:0] raw_oh, oth_oh;
   logic [IDXW-1:0] raw_idx, oth_idx;
   function automatic logic [IDXW-1:0] inc(input logic [IDXW-1:0] i);
      return i == IDXW'(N - 1) ? '0 : i + 1'b1;
   endfunction
   rr_pick #(.N(N), .IDXW(IDXW)) u_raw (
      .req_i(bus.req), .ptr_i(ptr_q), .found_o(raw_found), .onehot_o(raw_oh), .idx_o(raw_idx)
   );
   // The owner is masked out so a forced rotation can never re-pick it.
   rr_pick #(.N(N), .IDXW(IDXW)) u_oth (
      .req_i(bus.req & ~grant_q), .ptr_i(ptr_q), .found_o(oth_found), .onehot_o(oth_oh), .idx_o(oth_idx)
   );
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d = ptr_q;
      hold_d = hold_q;
      own = |(bus.req & grant_q);
      if (state_q == IDLE) begin
         if (raw_found) begin
            state_d = GRANT;
            grant_d = raw_oh;
            hold_d = '0;
            ptr_d = inc(raw_idx);
         end
      end else if (oth_found && (!own || hold_q == HMAX)) begin
         grant_d = oth_oh;
         hold_d = '0;
         ptr_d = inc(oth_idx);
      end else if (!own) begin
         state_d = IDLE;
         grant_d = '0;
      end else hold_d = hold_q == HMAX ? hold_q : hold_q + 1'b1;
      idx_d = IDXW'(oh2idx(32'(grant_d)));
   end
   always_ff @(posedge clk) begin
      if (res) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q <= '0;
         idx_q <= '0;
         hold_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q <= ptr_d;
         idx_q <= idx_d;
         hold_q <= hold_d;
      end
   end
   assign bus.grant = grant_q;
   assign bus.grant_valid = |grant_q;
   assign bus.grant_idx = idx_q;
endmodule
